// File: rtl/knn_vote_reader.sv
// Read-out end of the KNN sorter: walks the K nearest slots, looks up each neighbour's
// label, counts votes per class and reports the majority class (ties go to the lowest class).
module knn_vote_reader #(
    parameter int W      = 32,
    parameter int K      = 10,
    parameter int LW     = 4,
    parameter int NCLASS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W/4-1:0]  num_pts,
    output logic [3:0]      sel,
    input  logic [W/4-1:0]  idx_in,
    output logic [W/4-1:0]  lbl_addr,
    input  logic [LW-1:0]   lbl_data,
    output logic            busy,
    output logic            class_valid,
    output logic [LW-1:0]   class_out,
    output logic [3:0]      class_votes,
    output logic            empty,
    output logic            lbl_err
);
    localparam int IW = W / 4;
    localparam int CW = $clog2(NCLASS);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, SCAN, RESULT} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               n_q, n_d, sel_q, sel_d;
    logic                     acc_q, acc_d;
    logic [NCLASS-1:0][3:0]   vote_q, vote_d;
    logic [CW-1:0]            scan_q, scan_d;
    logic [LW-1:0]            best_class_q, best_class_d;
    logic [3:0]               best_cnt_q, best_cnt_d;
    logic                     busy_q, busy_d, class_valid_q, class_valid_d;
    logic [LW-1:0]            class_out_q, class_out_d;
    logic [3:0]               class_votes_q, class_votes_d;
    logic                     empty_q, empty_d, lbl_err_q, lbl_err_d;

    logic [3:0] n_start;
    logic       lbl_ok;

    assign n_start = (num_pts < IW'(K)) ? num_pts[3:0] : 4'(K);
    assign lbl_ok  = ({1'b0, lbl_data} < (LW+1)'(NCLASS));

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        sel_d         = '0;
        acc_d         = 1'b0;
        vote_d        = vote_q;
        scan_d        = scan_q;
        best_class_d  = best_class_q;
        best_cnt_d    = best_cnt_q;
        class_valid_d = 1'b0;
        class_out_d   = class_out_q;
        class_votes_d = class_votes_q;
        empty_d       = empty_q;
        lbl_err_d     = lbl_err_q;

        // Label for the slot issued last cycle arrives now (also covers DRAIN).
        if (acc_q) begin
            if (lbl_ok) begin
                for (int c = 0; c < NCLASS; c++)
                    if (lbl_data == LW'(c)) vote_d[c] = vote_q[c] + 4'd1;
            end else begin
                lbl_err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: if (start) begin
                vote_d        = '0;
                lbl_err_d     = 1'b0;
                class_out_d   = '0;
                class_votes_d = '0;
                best_class_d  = '0;
                best_cnt_d    = '0;
                scan_d        = '0;
                n_d           = n_start;
                if (n_start == 4'd0) begin
                    empty_d       = 1'b1;
                    class_valid_d = 1'b1;
                    state_d       = RESULT;
                end else begin
                    empty_d = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                acc_d = 1'b1;
                if (sel_q == n_q - 4'd1) state_d = DRAIN;
                else                     sel_d   = sel_q + 4'd1;
            end
            DRAIN: state_d = SCAN;
            SCAN: begin
                if (vote_q[scan_q] > best_cnt_q) begin
                    best_class_d = LW'(scan_q);
                    best_cnt_d   = vote_q[scan_q];
                end
                if (scan_q == CW'(NCLASS - 1)) begin
                    state_d       = RESULT;
                    class_valid_d = 1'b1;
                    class_out_d   = best_class_d;
                    class_votes_d = best_cnt_d;
                end else begin
                    scan_d = scan_q + CW'(1);
                end
            end
            RESULT: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            n_q           <= '0;
            sel_q         <= '0;
            acc_q         <= 1'b0;
            vote_q        <= '0;
            scan_q        <= '0;
            best_class_q  <= '0;
            best_cnt_q    <= '0;
            busy_q        <= 1'b0;
            class_valid_q <= 1'b0;
            class_out_q   <= '0;
            class_votes_q <= '0;
            empty_q       <= 1'b0;
            lbl_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            sel_q         <= sel_d;
            acc_q         <= acc_d;
            vote_q        <= vote_d;
            scan_q        <= scan_d;
            best_class_q  <= best_class_d;
            best_cnt_q    <= best_cnt_d;
            busy_q        <= busy_d;
            class_valid_q <= class_valid_d;
            class_out_q   <= class_out_d;
            class_votes_q <= class_votes_d;
            empty_q       <= empty_d;
            lbl_err_q     <= lbl_err_d;
        end
    end

    // The sorter index is combinational from sel, so the RAM sees the address in the slot's own cycle.
    assign lbl_addr    = (state_q == FETCH) ? idx_in : '0;
    assign sel         = sel_q;
    assign busy        = busy_q;
    assign class_valid = class_valid_q;
    assign class_out   = class_out_q;
    assign class_votes = class_votes_q;
    assign empty       = empty_q;
    assign lbl_err     = lbl_err_q;
endmodule

// File: tb/tb_knn_vote_reader.sv
// Directed bench for knn_vote_reader: a 16-class and a 4-class instance share a sorter/label RAM model.
module tb_knn_vote_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start16 = 1'b0, start4 = 1'b0;
    logic [7:0] num_pts = '0;
    logic [3:0] sel16, sel4, ld16, ld4, co16, co4, vt16, vt4;
    logic [7:0] idx16, idx4, addr16, addr4;
    logic       busy16, busy4, cv16, cv4, emp16, emp4, err16, err4;

    logic [7:0] idx_tab [16];
    logic [3:0] mem [256];
    logic [3:0] lbl_tab [10];

    assign idx16 = idx_tab[sel16];
    assign idx4  = idx_tab[sel4];
    always @(posedge clk) begin
        ld16 <= mem[addr16];
        ld4  <= mem[addr4];
    end

    knn_vote_reader #(.W(32), .K(10), .LW(4), .NCLASS(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .num_pts(num_pts), .sel(sel16),
        .idx_in(idx16), .lbl_addr(addr16), .lbl_data(ld16), .busy(busy16),
        .class_valid(cv16), .class_out(co16), .class_votes(vt16), .empty(emp16), .lbl_err(err16));

    knn_vote_reader #(.W(32), .K(10), .LW(4), .NCLASS(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .num_pts(num_pts), .sel(sel4),
        .idx_in(idx4), .lbl_addr(addr4), .lbl_data(ld4), .busy(busy4),
        .class_valid(cv4), .class_out(co4), .class_votes(vt4), .empty(emp4), .lbl_err(err4));

    logic       use4 = 1'b0;
    logic [3:0] m_sel, m_co, m_vt;
    logic [7:0] m_addr;
    logic       m_busy, m_cv, m_emp, m_err;
    assign m_sel  = use4 ? sel4  : sel16;
    assign m_addr = use4 ? addr4 : addr16;
    assign m_busy = use4 ? busy4 : busy16;
    assign m_cv   = use4 ? cv4   : cv16;
    assign m_co   = use4 ? co4   : co16;
    assign m_vt   = use4 ? vt4   : vt16;
    assign m_emp  = use4 ? emp4  : emp16;
    assign m_err  = use4 ? err4  : err16;

    typedef struct {
        int cls;
        int votes;
        int empty;
        int err;
        int lat;
        int n;
    } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
        total++;
        assert (obs === ex) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, ex);
        end
    endtask

    task automatic set_labels(input int l0, l1, l2, l3, l4, l5, l6, l7, l8, l9);
        lbl_tab[0] = 4'(l0); lbl_tab[1] = 4'(l1); lbl_tab[2] = 4'(l2); lbl_tab[3] = 4'(l3);
        lbl_tab[4] = 4'(l4); lbl_tab[5] = 4'(l5); lbl_tab[6] = 4'(l6); lbl_tab[7] = 4'(l7);
        lbl_tab[8] = 4'(l8); lbl_tab[9] = 4'(l9);
        for (int s = 0; s < 10; s++) mem[idx_tab[s]] = lbl_tab[s];
    endtask

    // Reference vote: strict greater-than scan from class 0, out-of-range labels flag an error.
    function automatic exp_t model(input int nc, input int num);
        exp_t e;
        int votes[16];
        int bc, bv;
        e.n = (num < 10) ? num : 10;
        e.err = 0;
        for (int c = 0; c < 16; c++) votes[c] = 0;
        for (int s = 0; s < e.n; s++) begin
            if (int'(lbl_tab[s]) < nc) votes[lbl_tab[s]]++;
            else e.err = 1;
        end
        bc = 0; bv = 0;
        for (int c = 0; c < nc; c++)
            if (votes[c] > bv) begin bc = c; bv = votes[c]; end
        e.cls   = bc;
        e.votes = bv;
        e.empty = (e.n == 0) ? 1 : 0;
        e.lat   = (e.n == 0) ? 1 : e.n + nc + 2;
        return e;
    endfunction

    task automatic run(input bit four, input int num, input int stray_k);
        exp_t e;
        bit got;
        use4 = four;
        sbq.push_back(model(four ? 4 : 16, num));
        @(negedge clk);
        num_pts = 8'(num);
        if (four) start4 = 1'b1; else start16 = 1'b1;
        @(negedge clk);
        got = 1'b0;
        for (int k = 1; k <= 60 && !got; k++) begin
            start4 = 1'b0; start16 = 1'b0;
            chk("sel",      m_sel,  (k <= sbq[0].n) ? 32'(k - 1) : 32'd0);
            chk("lbl_addr", m_addr, (k <= sbq[0].n) ? 32'(idx_tab[k - 1]) : 32'd0);
            chk("busy",     m_busy, 1);
            if (k == stray_k) begin
                if (four) start4 = 1'b1; else start16 = 1'b1;
            end
            if (m_cv) begin
                e = sbq.pop_front();
                got = 1'b1;
                chk("latency",     k,      e.lat);
                chk("class_out",   m_co,   e.cls);
                chk("class_votes", m_vt,   e.votes);
                chk("empty",       m_emp,  e.empty);
                chk("lbl_err",     m_err,  e.err);
            end else begin
                @(negedge clk);
            end
        end
        start4 = 1'b0; start16 = 1'b0;
        if (!got) begin
            chk("timeout", 0, 1);
            e = sbq.pop_front();
        end
        @(negedge clk);
        chk("busy_after",  m_busy, 0);
        chk("cv_after",    m_cv,   0);
        chk("class_held",  m_co,   e.cls);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int s = 0; s < 16; s++) idx_tab[s] = 8'(s * 7 + 11);

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_sel", sel16, 0);
        chk("rst_addr", addr16, 0);
        chk("rst_busy", busy16, 0);
        chk("rst_cv", cv16, 0);
        chk("rst_class", co16, 0);
        chk("rst_votes", vt16, 0);
        chk("rst_empty", emp16, 0);
        chk("rst_err", err16, 0);
        chk("rst_cv4", cv4, 0);
        rst = 1'b0;

        set_labels(3, 3, 5, 3, 5, 5, 5, 1, 3, 2);
        run(0, 20, 0);                  // tie 3 vs 5 -> 3
        set_labels(7, 7, 7, 7, 7, 7, 7, 7, 7, 7);
        run(0, 10, 15);                 // stray start in SCAN ignored
        set_labels(2, 9, 9, 4, 4, 4, 4, 4, 4, 4);
        run(0, 3, 0);                   // N limited by num_pts
        run(0, 0, 0);                   // empty run
        set_labels(1, 1, 0, 6, 0, 2, 1, 3, 0, 0);
        run(1, 10, 0);                  // out-of-range label on the 4-class unit

        // Abort during FETCH slot 4
        use4 = 1'b0;
        set_labels(5, 5, 5, 5, 5, 5, 5, 5, 5, 5);
        @(negedge clk);
        num_pts = 8'd10;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_sel", sel16, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_sel0", sel16, 0);
        chk("abort_addr", addr16, 0);
        chk("abort_busy", busy16, 0);
        chk("abort_cv", cv16, 0);
        chk("abort_class", co16, 0);
        chk("abort_votes", vt16, 0);
        chk("abort_err", err16, 0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (cv16 !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_cv", seen, 0);

        set_labels(2, 8, 2, 8, 2, 8, 8, 2, 8, 1);
        run(0, 10, 0);                  // fresh counts after abort -> 8 with 5

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
